// File: rtl/aurora_tx_arbiter.sv
// Round-robin, frame-level arbiter sharing one Aurora TX user-data stream between NUM_REQ sources.
// Define TX_FRAME_CNT_EN to add the frame_count / drop_count statistics ports.
module aurora_tx_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = 16,
  parameter int MAX_WORDS = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      channel_up,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] src_data,
  input  logic [NUM_REQ-1:0]        src_valid,
  input  logic [NUM_REQ-1:0]        src_last,
  output logic [NUM_REQ-1:0]        src_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic [DATA_W-1:0]         tx_tdata,
  output logic                      tx_tvalid,
  output logic                      tx_tlast,
  output logic [DATA_W/8-1:0]       tx_tkeep,
  input  logic                      tx_tready,
  output logic                      busy,
  output logic                      trunc_err,
  output logic [1:0]                dbg_state
`ifdef TX_FRAME_CNT_EN
  ,
  output logic [15:0]               frame_count,
  output logic [15:0]               drop_count
`endif
);

  // Handshake rule on both sides: a word moves at a clock edge where valid and ready are both high;
  // the sender holds data/last stable while valid & ~ready, and ready never depends on valid.
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DISCARD, S_DRAIN} state_e;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_WORDS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WORDS - 1);

  state_e              state_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [IDX_W-1:0]    gidx_q;
  logic [IDX_W-1:0]    last_grant_q;
  logic [CNT_W-1:0]    word_cnt_q;
  logic [DATA_W-1:0]   tx_tdata_q;
  logic                tx_tvalid_q;
  logic                tx_tlast_q;
  logic [DATA_W/8-1:0] tx_tkeep_q;
  logic                trunc_err_q;
`ifdef TX_FRAME_CNT_EN
  logic [15:0]         frame_cnt_q;
  logic [15:0]         drop_cnt_q;
`endif

  logic                found;
  logic [IDX_W-1:0]    pick;
  logic [IDX_W-1:0]    cand;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_valid;
  logic                sel_last;
  logic                accept;
  logic                at_max;

  // Scan downwards so the last hit is the first requester after last_grant_q (with wrap).
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    src_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx_q == IDX_W'(i)) begin
        sel_data  = src_data[i*DATA_W +: DATA_W];
        sel_valid = src_valid[i];
        sel_last  = src_last[i];
        if (state_q == S_XFER)
          src_ready[i] = channel_up & (~tx_tvalid_q | tx_tready);
        else if (state_q == S_DISCARD)
          src_ready[i] = 1'b1;
      end
    end
  end

  assign accept = sel_valid & (|(src_ready & grant_q));
  assign at_max = (word_cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      gidx_q       <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      word_cnt_q   <= '0;
      tx_tdata_q   <= '0;
      tx_tvalid_q  <= 1'b0;
      tx_tlast_q   <= 1'b0;
      tx_tkeep_q   <= '0;
      trunc_err_q  <= 1'b0;
`ifdef TX_FRAME_CNT_EN
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
`endif
    end else begin
      trunc_err_q <= 1'b0;
      if (tx_tvalid_q && tx_tready) tx_tvalid_q <= 1'b0;
`ifdef TX_FRAME_CNT_EN
      if (tx_tvalid_q && tx_tready && tx_tlast_q) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (state_q == S_DISCARD && accept) drop_cnt_q <= drop_cnt_q + 16'd1;
`endif
      // Losing the channel abandons the frame; last_grant_q is kept so the owner loses its turn.
      if (state_q != S_IDLE && !channel_up) begin
        state_q     <= S_IDLE;
        grant_q     <= '0;
        word_cnt_q  <= '0;
        tx_tvalid_q <= 1'b0;
        tx_tlast_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (channel_up && found) begin
              grant_q      <= NUM_REQ'(1) << pick;
              gidx_q       <= pick;
              last_grant_q <= pick;
              word_cnt_q   <= '0;
              state_q      <= S_XFER;
            end
          end
          S_XFER: begin
            if (accept) begin
              tx_tdata_q  <= sel_data;
              tx_tkeep_q  <= '1;
              tx_tvalid_q <= 1'b1;
              tx_tlast_q  <= sel_last | at_max;
              word_cnt_q  <= word_cnt_q + CNT_W'(1);
              if (sel_last) begin
                state_q <= S_DRAIN;
              end else if (at_max) begin
                trunc_err_q <= 1'b1;
                state_q     <= S_DISCARD;
              end
            end
          end
          S_DISCARD: begin
            if (accept && sel_last) state_q <= S_DRAIN;
          end
          S_DRAIN: begin
            if (!tx_tvalid_q || tx_tready) begin
              grant_q <= '0;
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign grant     = grant_q;
  assign tx_tdata  = tx_tdata_q;
  assign tx_tvalid = tx_tvalid_q;
  assign tx_tlast  = tx_tlast_q;
  assign tx_tkeep  = tx_tkeep_q;
  assign trunc_err = trunc_err_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;
`ifdef TX_FRAME_CNT_EN
  assign frame_count = frame_cnt_q;
  assign drop_count  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Directed bench for aurora_tx_arbiter: frame-level expected-word and expected-grant queues,
// per-cycle checking at the falling edge, plus hand-computed literal checks per scenario.
module tb_aurora_tx_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int DATA_W    = 16;
  localparam int MAX_WORDS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        channel_up = 1'b0;
  logic        tx_tready = 1'b0;
  logic [1:0]  req = '0;
  logic [31:0] src_data = '0;
  logic [1:0]  src_valid = '0;
  logic [1:0]  src_last = '0;
  logic [1:0]  src_ready;
  logic [1:0]  grant;
  logic [15:0] tx_tdata;
  logic        tx_tvalid;
  logic        tx_tlast;
  logic [1:0]  tx_tkeep;
  logic        busy;
  logic        trunc_err;
  logic [1:0]  dbg_state;
`ifdef TX_FRAME_CNT_EN
  logic [15:0] frame_count;
  logic [15:0] drop_count;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  aurora_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk(clk), .reset(reset), .channel_up(channel_up), .req(req),
    .src_data(src_data), .src_valid(src_valid), .src_last(src_last), .src_ready(src_ready),
    .grant(grant), .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast),
    .tx_tkeep(tx_tkeep), .tx_tready(tx_tready), .busy(busy), .trunc_err(trunc_err),
    .dbg_state(dbg_state)
`ifdef TX_FRAME_CNT_EN
    , .frame_count(frame_count), .drop_count(drop_count)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [16:0] src_q0[$];
  logic [16:0] src_q1[$];
  logic [16:0] exp_q[$];
  logic [1:0]  exp_grant_q[$];
  logic [15:0] obs_d[$];
  logic        obs_l[$];
  int          obs_t[$];
  int          acc_cnt[2];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          trunc_seen = 0;
  int          exp_trunc = 0;
  int          cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic present();
    src_valid[0] = (src_q0.size() > 0);
    src_valid[1] = (src_q1.size() > 0);
    src_data     = '0;
    src_last     = '0;
    if (src_q0.size() > 0) begin src_data[15:0]  = src_q0[0][15:0]; src_last[0] = src_q0[0][16]; end
    if (src_q1.size() > 0) begin src_data[31:16] = src_q1[0][15:0]; src_last[1] = src_q1[0][16]; end
    req = src_valid;
  endtask

  task automatic send_frame(input int src, input logic [15:0] base, input logic [15:0] step, input int n);
    logic [15:0] w;
    for (int k = 0; k < n; k++) begin
      w = base + 16'(k) * step;
      if (src == 0) src_q0.push_back({k == n - 1, w});
      else          src_q1.push_back({k == n - 1, w});
    end
    present();
  endtask

  // Model: a frame of n words leaves as min(n, MAX_WORDS) words, tlast on the final one; longer frames truncate.
  task automatic expect_frame(input logic [15:0] base, input logic [15:0] step, input int n);
    int m;
    m = (n > MAX_WORDS) ? MAX_WORDS : n;
    for (int k = 0; k < m; k++) exp_q.push_back({k == m - 1, base + 16'(k) * step});
    if (n > MAX_WORDS) exp_trunc++;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while ((src_q0.size() > 0 || src_q1.size() > 0 || exp_q.size() > 0 || busy || tx_tvalid)
           && n < max_cyc) begin
      tick();
      n++;
    end
    chk("idle_timeout", n >= max_cyc, 0);
    tick();
  endtask

  // Source side: a word leaves the source queue when valid & ready were seen before the edge.
  initial begin
    logic [1:0] acc;
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;
    forever begin
      @(negedge clk);
      acc = src_valid & src_ready;
      @(posedge clk);
      #1;
      if (acc[0] && src_q0.size() > 0) begin void'(src_q0.pop_front()); acc_cnt[0]++; end
      if (acc[1] && src_q1.size() > 0) begin void'(src_q1.pop_front()); acc_cnt[1]++; end
      present();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [1:0]  prev_grant;
    logic        prev_stall, prev_chan, prev_last, prev_trunc;
    logic [15:0] prev_data;
    logic [16:0] e;
    logic [1:0]  eg;
    prev_grant = '0; prev_stall = 1'b0; prev_chan = 1'b0; prev_last = 1'b0;
    prev_trunc = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        prev_grant = '0; prev_stall = 1'b0; prev_trunc = 1'b0; prev_chan = 1'b0;
      end else begin
        chk("ready_outside_grant", src_ready & ~grant, 0);
        if (tx_tvalid && !tx_tready && !tx_tlast) chk("ready_during_stall", src_ready, 0);
        if (prev_stall && prev_chan) begin
          chk("hold_tvalid", tx_tvalid, 1);
          chk("hold_tdata", tx_tdata, prev_data);
          chk("hold_tlast", tx_tlast, prev_last);
        end
        if (prev_grant == 2'b00 && grant != 2'b00) begin
          if (exp_grant_q.size() == 0) chk("unexpected_grant", grant, 0);
          else begin
            eg = exp_grant_q.pop_front();
            chk("grant_order", grant, eg);
          end
          chk("busy_on_grant", busy, 1);
        end
        if (tx_tvalid && tx_tready && channel_up) begin
          if (exp_q.size() == 0) chk("unexpected_word", tx_tdata, 32'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            chk("tdata", tx_tdata, e[15:0]);
            chk("tlast", tx_tlast, e[16]);
            chk("tkeep", tx_tkeep, 2'b11);
          end
          obs_d.push_back(tx_tdata);
          obs_l.push_back(tx_tlast);
          obs_t.push_back(cyc);
        end
        if (trunc_err) begin
          trunc_seen++;
          chk("trunc_pulse_width", prev_trunc, 0);
        end
        prev_trunc = trunc_err;
        prev_grant = grant;
        prev_stall = tx_tvalid & ~tx_tready;
        prev_data  = tx_tdata;
        prev_last  = tx_tlast;
        prev_chan  = channel_up;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 200000", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int b, n, a0;
    present();
    repeat (2) tick();
    chk("rst_grant", grant, 0);
    chk("rst_tvalid", tx_tvalid, 0);
    chk("rst_tlast", tx_tlast, 0);
    chk("rst_tdata", tx_tdata, 0);
    chk("rst_tkeep", tx_tkeep, 0);
    chk("rst_busy", busy, 0);
    chk("rst_trunc", trunc_err, 0);
    chk("rst_src_ready", src_ready, 0);
    reset = 1'b1;
    channel_up = 1'b1;
    tx_tready = 1'b1;
    tick();

    // Single 3-word frame from requester 0.
    b = obs_d.size();
    exp_grant_q.push_back(2'b01);
    expect_frame(16'h1111, 16'h1111, 3);
    send_frame(0, 16'h1111, 16'h1111, 3);
    wait_idle(50);
    chk("t1_word0", obs_d[b], 16'h1111);
    chk("t1_word2", obs_d[b+2], 16'h3333);
    chk("t1_last1", obs_l[b+1], 0);
    chk("t1_last2", obs_l[b+2], 1);
    chk("t1_consecutive", obs_t[b+2] - obs_t[b], 2);
    chk("t1_busy_after", busy, 0);

    // Both requesters with two 2-word frames each; last owner was 0, so 1 goes first.
    b = obs_d.size();
    exp_grant_q.push_back(2'b10); exp_grant_q.push_back(2'b01);
    exp_grant_q.push_back(2'b10); exp_grant_q.push_back(2'b01);
    expect_frame(16'hB000, 1, 2); expect_frame(16'hA000, 1, 2);
    expect_frame(16'hB100, 1, 2); expect_frame(16'hA100, 1, 2);
    send_frame(0, 16'hA000, 1, 2); send_frame(0, 16'hA100, 1, 2);
    send_frame(1, 16'hB000, 1, 2); send_frame(1, 16'hB100, 1, 2);
    wait_idle(100);
    chk("t2_first", obs_d[b], 16'hB000);
    chk("t2_third", obs_d[b+2], 16'hA000);
    chk("t2_last", obs_d[b+7], 16'hA101);

    // Backpressure: tx_tready low for 4 cycles mid-frame; exactly MAX_WORDS words, no truncation.
    b = obs_d.size();
    exp_grant_q.push_back(2'b01);
    expect_frame(16'hC000, 1, 4);
    send_frame(0, 16'hC000, 1, 4);
    n = 0;
    while (obs_d.size() < b + 2 && n < 50) begin tick(); n++; end
    chk("t3_wait_timeout", n >= 50, 0);
    tx_tready = 1'b0;
    repeat (4) begin
      tick();
      chk("t3_ready_low", src_ready, 0);
      chk("t3_tvalid_held", tx_tvalid, 1);
    end
    tx_tready = 1'b1;
    wait_idle(50);
    chk("t3_word2", obs_d[b+2], 16'hC002);
    chk("t3_word3", obs_d[b+3], 16'hC003);
    chk("t3_last3", obs_l[b+3], 1);
    chk("t3_no_trunc", trunc_seen, 0);

    // Truncation: 6-word frame from 1 leaves as 4 words, then requester 0 proceeds.
    b = obs_d.size();
    exp_grant_q.push_back(2'b10); exp_grant_q.push_back(2'b01);
    expect_frame(16'hD000, 1, 6); expect_frame(16'hE000, 1, 2);
    send_frame(1, 16'hD000, 1, 6);
    send_frame(0, 16'hE000, 1, 2);
    wait_idle(100);
    chk("t4_word3", obs_d[b+3], 16'hD003);
    chk("t4_last3", obs_l[b+3], 1);
    chk("t4_next", obs_d[b+4], 16'hE000);
    chk("t4_trunc_pulses", trunc_seen, 1);
`ifdef TX_FRAME_CNT_EN
    chk("t4_drop_count", drop_count, 2);
    chk("t4_frame_count", frame_count, 8);
`endif

    // Channel loss after the 2nd word of requester 1: only the 1st word is delivered.
    b = obs_d.size();
    exp_grant_q.push_back(2'b10);
    exp_q.push_back({1'b0, 16'hF000});
    a0 = acc_cnt[1];
    send_frame(1, 16'hF000, 1, 4);
    n = 0;
    while (acc_cnt[1] < a0 + 2 && n < 50) begin tick(); n++; end
    chk("t5_wait_timeout", n >= 50, 0);
    channel_up = 1'b0;
    tick();
    chk("t5_tvalid", tx_tvalid, 0);
    chk("t5_tlast", tx_tlast, 0);
    chk("t5_grant", grant, 0);
    chk("t5_busy", busy, 0);
    chk("t5_src_ready", src_ready, 0);
    repeat (3) begin
      tick();
      chk("t5_no_grant_down", grant, 0);
      chk("t5_idle_down", busy, 0);
    end
    exp_grant_q.push_back(2'b01); exp_grant_q.push_back(2'b10);
    expect_frame(16'h5A00, 1, 2);
    expect_frame(16'hF002, 1, 2);
    send_frame(0, 16'h5A00, 1, 2);
    channel_up = 1'b1;
    wait_idle(100);
    chk("t5_first_after", obs_d[b+1], 16'h5A00);
    chk("t5_resume", obs_d[b+3], 16'hF002);

    // Asynchronous reset in the middle of a frame.
    exp_grant_q.push_back(2'b01);
    expect_frame(16'h9000, 1, 4);
    send_frame(0, 16'h9000, 1, 4);
    n = 0;
    while (!tx_tvalid && n < 50) begin tick(); n++; end
    chk("t6_wait_timeout", n >= 50, 0);
    #1 reset = 1'b0;
    #1;
    chk("t6_tvalid", tx_tvalid, 0);
    chk("t6_grant", grant, 0);
    chk("t6_busy", busy, 0);
    chk("t6_tdata", tx_tdata, 0);
    chk("t6_tlast", tx_tlast, 0);
    chk("t6_tkeep", tx_tkeep, 0);
    chk("t6_src_ready", src_ready, 0);
    src_q0.delete(); src_q1.delete(); exp_q.delete(); exp_grant_q.delete();
    present();
    repeat (2) tick();
    reset = 1'b1;
    b = obs_d.size();
    exp_grant_q.push_back(2'b01); exp_grant_q.push_back(2'b10);
    expect_frame(16'h8000, 1, 2); expect_frame(16'h7000, 1, 2);
    send_frame(1, 16'h7000, 1, 2);
    send_frame(0, 16'h8000, 1, 2);
    wait_idle(100);
    chk("t6_first_after_reset", obs_d[b], 16'h8000);
    chk("t6_second_after_reset", obs_d[b+2], 16'h7000);

    repeat (3) tick();
    chk("end_exp_words_left", exp_q.size(), 0);
    chk("end_exp_grants_left", exp_grant_q.size(), 0);
    chk("end_trunc_total", trunc_seen, exp_trunc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/aurora_tx_arbiter.md
Name: aurora_tx_arbiter

Overview:
- Shares the single Aurora TX user-data stream (tdata/tvalid/tlast/tkeep, 16-bit) between NUM_REQ frame producers, e.g. several Data_FSM-style frame sources.
- Round-robin frame-level arbitration: a granted producer owns the link until its frame ends.
- One registered output stage with tready backpressure; max-frame-length truncation; abort on channel loss.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
DATA_W, 16, data word width (multiple of 8)
MAX_WORDS, 64, maximum words per frame before forced tlast (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
channel_up  in  1  Aurora channel up
req  in  NUM_REQ  requester i has a frame pending
src_data  in  NUM_REQ*DATA_W  requester i word at [i*DATA_W +: DATA_W]
src_valid  in  NUM_REQ  requester word valid
src_last  in  NUM_REQ  requester word is last of frame
src_ready  out  NUM_REQ  word accepted from requester i when src_valid[i]&src_ready[i]
grant  out  NUM_REQ  one-hot current owner (registered)
tx_tdata  out  DATA_W  TX data
tx_tvalid  out  1  TX valid
tx_tlast  out  1  TX end of frame
tx_tkeep  out  DATA_W/8  TX byte enables
tx_tready  in  1  TX ready from Aurora core
busy  out  1  state != IDLE
trunc_err  out  1  one-cycle pulse when a frame is truncated

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; grant, src_ready, tx_tdata, tx_tvalid, tx_tlast, tx_tkeep, busy, trunc_err, word_cnt = 0; last_grant = NUM_REQ-1, so requester 0 wins first.
- States:
  - IDLE: if channel_up & |req, select the first set req bit searching from last_grant+1 with wrap. Register grant one-hot, update last_grant, word_cnt=0 -> XFER. Otherwise stay.
  - XFER: src_ready[g] = channel_up & (~tx_tvalid | tx_tready); all other src_ready bits 0 (combinational from registered state). On accept, load the output register the next edge:
    - tx_tdata = src_data of g; tx_tkeep = all ones; tx_tvalid = 1.
    - tx_tlast = src_last[g] | (word_cnt == MAX_WORDS-1); word_cnt++.
    - tlast from src_last -> DRAIN.
    - tlast forced with src_last=0 -> pulse trunc_err, go DISCARD.
  - DISCARD: src_ready[g]=1; words are dropped (not forwarded) until src_last[g] is accepted -> DRAIN.
  - DRAIN: src_ready=0. When the output register empties (tx_tvalid & tx_tready, or already empty), clear grant -> IDLE.
- Output register: tx_tvalid clears on tx_tready when no new word loads that cycle. A load and a tx_tready in the same cycle give a back-to-back transfer with no bubble. Outputs hold stable while tx_tvalid & ~tx_tready.
- Latency: word accepted at edge t appears on tx_* after edge t. One idle cycle minimum between frames (DRAIN->IDLE->grant).
- req is sampled only in IDLE. req drops during XFER are ignored; the frame ends only on src_last or truncation.
- channel_up low in any non-IDLE state:
  - Next edge clears tx_tvalid, tx_tlast, grant, word_cnt, src_ready; state -> IDLE.
  - last_grant is kept, so the aborted requester loses its turn.
  - No trunc_err.
- channel_up low in IDLE: no grant issued.
- word_cnt width is clog2(MAX_WORDS)+1; it never wraps, and resets on each grant.

Optional Feature:
TX_FRAME_CNT_EN
- Defined: adds output ports frame_count[15:0] and drop_count[15:0], reset 0.
  - frame_count increments once per frame sent with tlast (tx_tvalid & tx_tready & tx_tlast).
  - drop_count increments per word discarded in DISCARD.
  - Both wrap 0xFFFF->0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Req0 frame 0x1111,0x2222,0x3333 (last on 3rd), tx_tready=1, channel_up=1 -> tx shows the 3 words on consecutive cycles, tlast on 0x3333, tkeep=2'b11, grant=01, then IDLE.
- req=2'b11 held, each source sends 2-word frames -> grant order 01,10,01,10; no word interleaving between frames.
- tx_tready held low 4 cycles mid-frame -> tx_tdata/tlast stable, src_ready=0, no word lost or duplicated after release.
- MAX_WORDS=4, source sends 6 words -> 4 words out, tlast on 4th, trunc_err one pulse, words 5-6 dropped (drop_count=2 with TX_FRAME_CNT_EN), next grant proceeds.
- channel_up drops after 2nd word of requester 1 -> next cycle tx_tvalid=0, grant=0, busy=0. After channel_up returns with both req set, requester 0 is granted.
- reset asserted mid-XFER with tx_tvalid=1 -> all outputs 0 immediately (asynchronous). After release, requester 0 wins first.
